// File: rtl/gshare_branch_predictor_if.sv
// Lookup/update bundle for the gshare predictor. The predictor uses the
// slave modport and the requester uses the master modport.
interface gshare_branch_predictor_if #(
    parameter int HIST_W = 8
);
    logic              pred_valid;
    logic [63:0]       pred_ip;
    logic              pred_out_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid;
    logic [63:0]       upd_ip;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_taken;
    logic              hist_flush;

    modport master (
        output pred_valid, pred_ip,
        output upd_valid, upd_ip, upd_hist, upd_taken, hist_flush,
        input  pred_out_valid, pred_taken, pred_hist
    );

    modport slave (
        input  pred_valid, pred_ip,
        input  upd_valid, upd_ip, upd_hist, upd_taken, hist_flush,
        output pred_out_valid, pred_taken, pred_hist
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Tagged gshare/bimodal branch predictor: one-cycle registered lookup,
// saturating-counter update with allocate-on-miss, and a global history register.
module gshare_branch_predictor #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 16,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int GSHARE     = 1
) (
    input  logic clk,
    input  logic reset,
    gshare_branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << INDEX_BITS;
    // Zero-length history still needs a one-bit carrier; it is held at zero.
    localparam int HW = (HIST_BITS > 0) ? HIST_BITS : 1;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
    localparam logic [CTR_BITS-1:0] WEAK_T   = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] WEAK_NT  = {1'b0, {(CTR_BITS-1){1'b1}}};

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem [DEPTH];
    logic [CTR_BITS-1:0] ctr_mem [DEPTH];
    logic [HW-1:0]       ghr;
    logic [HW-1:0]       ghr_next;

    logic [INDEX_BITS-1:0] p_idx;
    logic [TAG_BITS-1:0]   p_tag;
    logic                  p_hit;

    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic [CTR_BITS-1:0]   u_ctr;
    logic [CTR_BITS-1:0]   u_ctr_next;

    logic unused_bits;

    function automatic logic [INDEX_BITS-1:0] make_index(
        input logic [INDEX_BITS-1:0] low,
        input logic [HW-1:0]         hist
    );
        logic [INDEX_BITS-1:0] ext;
        ext = '0;
        if (GSHARE != 0 && HIST_BITS > 0) begin
            ext[HW-1:0] = hist;
        end
        return low ^ ext;
    endfunction

    always_comb begin
        p_idx = make_index(bp.pred_ip[INDEX_BITS-1:0], ghr);
        p_tag = bp.pred_ip[INDEX_BITS +: TAG_BITS];
        p_hit = valid_q[p_idx] && (tag_mem[p_idx] == p_tag) && ctr_mem[p_idx][CTR_BITS-1];
    end

    always_comb begin
        u_idx      = make_index(bp.upd_ip[INDEX_BITS-1:0], bp.upd_hist);
        u_tag      = bp.upd_ip[INDEX_BITS +: TAG_BITS];
        u_hit      = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
        u_ctr      = ctr_mem[u_idx];
        u_ctr_next = u_ctr;
        if (!u_hit) begin
            u_ctr_next = bp.upd_taken ? WEAK_T : WEAK_NT;
        end else if (bp.upd_taken) begin
            u_ctr_next = (u_ctr == CTR_MAX) ? u_ctr : u_ctr + CTR_BITS'(1);
        end else begin
            u_ctr_next = (u_ctr == CTR_MIN) ? u_ctr : u_ctr - CTR_BITS'(1);
        end
    end

    always_comb begin
        ghr_next = '0;
        if (HIST_BITS > 0) begin
            ghr_next = (ghr << 1) | HW'(bp.upd_taken);
        end
    end

    // Table read and history snapshot both use pre-edge state, so a
    // same-cycle update to the same entry is not seen by this lookup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp.pred_out_valid <= 1'b0;
            bp.pred_taken     <= 1'b0;
            bp.pred_hist      <= '0;
            valid_q           <= '0;
            ghr               <= '0;
        end else begin
            bp.pred_out_valid <= bp.pred_valid;
            bp.pred_taken     <= bp.pred_valid && p_hit;
            if (bp.pred_valid) begin
                bp.pred_hist <= ghr;
            end
            if (bp.upd_valid) begin
                valid_q[u_idx] <= 1'b1;
            end
            if (bp.hist_flush) begin
                ghr <= '0;
            end else if (bp.upd_valid) begin
                ghr <= ghr_next;
            end
        end
    end

    // Tag and counter storage is not reset; the valid bit guards it.
    always_ff @(posedge clk) begin
        if (bp.upd_valid && !reset) begin
            tag_mem[u_idx] <= u_tag;
            ctr_mem[u_idx] <= u_ctr_next;
        end
    end

    assign unused_bits = ^{bp.pred_ip, bp.upd_ip, bp.upd_hist};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench: a bimodal instance (GSHARE=0) and a gshare instance
// (GSHARE=1) driven with directed vectors, checked by a negedge monitor.
module tb_gshare_branch_predictor;

    typedef struct packed {
        logic       taken;
        logic [7:0] hist;
    } exp_t;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    gshare_branch_predictor_if #(.HIST_W(8)) if0 ();
    gshare_branch_predictor_if #(.HIST_W(8)) if1 ();

    gshare_branch_predictor #(
        .INDEX_BITS(8), .TAG_BITS(16), .HIST_BITS(8), .CTR_BITS(2), .GSHARE(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bp    (if0)
    );

    gshare_branch_predictor #(
        .INDEX_BITS(8), .TAG_BITS(16), .HIST_BITS(8), .CTR_BITS(2), .GSHARE(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bp    (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if0.pred_valid = 1'b0; if0.upd_valid = 1'b0; if0.hist_flush = 1'b0;
        if1.pred_valid = 1'b0; if1.upd_valid = 1'b0; if1.hist_flush = 1'b0;
    endtask

    task automatic apply_lookup(input int sel, input logic [63:0] ip,
                                input logic t, input logic [7:0] h);
        exp_t e;
        e.taken = t;
        e.hist  = h;
        if (sel == 0) begin
            if0.pred_valid = 1'b1; if0.pred_ip = ip; q0.push_back(e);
        end else begin
            if1.pred_valid = 1'b1; if1.pred_ip = ip; q1.push_back(e);
        end
        tick();
        clear_inputs();
    endtask

    task automatic apply_update(input int sel, input logic [63:0] ip, input logic [7:0] h,
                                input logic t, input logic flush);
        if (sel == 0) begin
            if0.upd_valid = 1'b1; if0.upd_ip = ip; if0.upd_hist = h;
            if0.upd_taken = t; if0.hist_flush = flush;
        end else begin
            if1.upd_valid = 1'b1; if1.upd_ip = ip; if1.upd_hist = h;
            if1.upd_taken = t; if1.hist_flush = flush;
        end
        tick();
        clear_inputs();
    endtask

    always @(negedge clk) begin
        if (if0.pred_out_valid) begin
            if (q0.size() == 0) begin
                check_output("dut0 unexpected pred_out_valid", 8'd1, 8'd0);
            end else begin
                mon_e = q0.pop_front();
                check_output("dut0 pred_taken", {7'd0, if0.pred_taken}, {7'd0, mon_e.taken});
                check_output("dut0 pred_hist", if0.pred_hist, mon_e.hist);
            end
        end
        if (if1.pred_out_valid) begin
            if (q1.size() == 0) begin
                check_output("dut1 unexpected pred_out_valid", 8'd1, 8'd0);
            end else begin
                mon_e = q1.pop_front();
                check_output("dut1 pred_taken", {7'd0, if1.pred_taken}, {7'd0, mon_e.taken});
                check_output("dut1 pred_hist", if1.pred_hist, mon_e.hist);
            end
        end
    end

    initial begin
        reset = 1'b1;
        if0.pred_ip = '0; if0.upd_ip = '0; if0.upd_hist = '0; if0.upd_taken = 1'b0;
        if1.pred_ip = '0; if1.upd_ip = '0; if1.upd_hist = '0; if1.upd_taken = 1'b0;
        clear_inputs();
        tick();
        tick();

        // Requests during reset must be ignored entirely
        if0.pred_valid = 1'b1; if0.pred_ip = 64'h1000;
        if1.pred_valid = 1'b1; if1.pred_ip = 64'h1000;
        if0.upd_valid = 1'b1; if0.upd_ip = 64'h1000; if0.upd_hist = 8'h00; if0.upd_taken = 1'b1;
        tick();
        clear_inputs();
        @(negedge clk);
        check_output("reset dut0 pred_out_valid", {7'd0, if0.pred_out_valid}, 8'd0);
        check_output("reset dut0 pred_taken", {7'd0, if0.pred_taken}, 8'd0);
        check_output("reset dut0 pred_hist", if0.pred_hist, 8'd0);
        check_output("reset dut1 pred_out_valid", {7'd0, if1.pred_out_valid}, 8'd0);
        check_output("reset dut1 pred_taken", {7'd0, if1.pred_taken}, 8'd0);
        check_output("reset dut1 pred_hist", if1.pred_hist, 8'd0);
        tick();
        reset = 1'b0;
        tick();

        apply_lookup(0, 64'h1000, 1'b0, 8'h00);
        apply_lookup(1, 64'h1000, 1'b0, 8'h00);

        // Bimodal: saturation at 3 and at 0
        apply_update(0, 64'h1004, 8'h00, 1'b1, 1'b0);
        apply_update(0, 64'h1004, 8'h00, 1'b1, 1'b0);
        apply_update(0, 64'h1004, 8'h00, 1'b1, 1'b0);
        apply_lookup(0, 64'h1004, 1'b1, 8'h07);
        apply_update(0, 64'h1004, 8'h00, 1'b0, 1'b0);
        apply_lookup(0, 64'h1004, 1'b1, 8'h0E);
        apply_update(0, 64'h1004, 8'h00, 1'b0, 1'b0);
        apply_lookup(0, 64'h1004, 1'b0, 8'h1C);
        apply_update(0, 64'h1004, 8'h00, 1'b0, 1'b0);
        apply_update(0, 64'h1004, 8'h00, 1'b0, 1'b0);
        apply_update(0, 64'h1004, 8'h00, 1'b1, 1'b0);
        apply_lookup(0, 64'h1004, 1'b0, 8'hE1);
        apply_update(0, 64'h1004, 8'h00, 1'b1, 1'b0);
        apply_lookup(0, 64'h1004, 1'b1, 8'hC3);

        // Bimodal: tag mismatch misses, then replacement with weak not-taken
        apply_update(0, 64'h1008, 8'h00, 1'b1, 1'b0);
        apply_lookup(0, 64'h1008, 1'b1, 8'h87);
        apply_lookup(0, 64'h101008, 1'b0, 8'h87);
        apply_update(0, 64'h101008, 8'h00, 1'b0, 1'b0);
        apply_lookup(0, 64'h101008, 1'b0, 8'h0E);
        apply_lookup(0, 64'h1008, 1'b0, 8'h0E);
        apply_update(0, 64'h101008, 8'h00, 1'b1, 1'b0);
        apply_lookup(0, 64'h101008, 1'b1, 8'h1D);

        // Gshare: history T,T,NT gives 0b110 and XOR-ed indexing
        apply_update(1, 64'h2000, 8'h00, 1'b1, 1'b0);
        apply_update(1, 64'h2000, 8'h00, 1'b1, 1'b0);
        apply_update(1, 64'h2000, 8'h00, 1'b0, 1'b0);
        apply_lookup(1, 64'h0006, 1'b0, 8'h06);
        apply_lookup(1, 64'h2006, 1'b1, 8'h06);
        apply_lookup(1, 64'h2000, 1'b0, 8'h06);
        apply_update(1, 64'h3001, 8'h00, 1'b1, 1'b1);
        apply_lookup(1, 64'h3001, 1'b1, 8'h00);

        // Gshare: same-cycle lookup and first update to the same index
        if1.upd_valid = 1'b1; if1.upd_ip = 64'h4005; if1.upd_hist = 8'h00; if1.upd_taken = 1'b1;
        apply_lookup(1, 64'h4005, 1'b0, 8'h00);
        apply_lookup(1, 64'h4004, 1'b1, 8'h01);

        // Reset between a lookup and its response discards it and all entries
        if0.pred_valid = 1'b1; if0.pred_ip = 64'h101008;
        tick();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        check_output("reset discard dut0 pred_out_valid", {7'd0, if0.pred_out_valid}, 8'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        apply_lookup(0, 64'h101008, 1'b0, 8'h00);
        apply_lookup(0, 64'h1004, 1'b0, 8'h00);
        apply_lookup(1, 64'h4005, 1'b0, 8'h00);
        apply_lookup(1, 64'h3001, 1'b0, 8'h00);

        for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) begin
            tick();
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            check_output("response timeout pending", 8'(q0.size() + q1.size()), 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
